antic_scan_timer: RTL and testbench

Video scan timing generator that sits directly upstream of the ANTIC display-list engine. It runs one count per colour clock and produces `hblank`, `vblank`, `VCOUNT` and line/frame strobes for ANTIC. It also generates the CPU `RDY` stall for WSYNC writes and the NMI request, with NMIST status for the DLI and VBI sources.

---
 rtl/antic_timing_pkg.sv | 26 ++
 rtl/scan_counter.sv | 56 +++++
 rtl/antic_scan_timer.sv | 134 +++++++++++++
 tb/tb_antic_scan_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/antic_timing_pkg.sv
// rtl/antic_timing_pkg.sv - shared timing constants, NMIST bit indices and FSM encodings
package antic_timing_pkg;

  localparam int unsigned H_TOTAL       = 228;
  localparam int unsigned HBLANK_END    = 68;
  localparam int unsigned V_TOTAL       = 262;
  localparam int unsigned VBLANK_END    = 8;
  localparam int unsigned VBLANK_START  = 248;
  localparam int unsigned WSYNC_RELEASE = 220;
  localparam int unsigned NMI_H_POS     = 16;

  localparam int NMIST_DLI = 7;
  localparam int NMIST_VBI = 6;

  typedef enum logic {
    WS_RUN  = 1'b0,
    WS_WAIT = 1'b1
  } wsync_state_t;

  typedef enum logic [1:0] {
    NMI_IDLE = 2'd0,
    NMI_P1   = 2'd1,
    NMI_P2   = 2'd2
  } nmi_state_t;

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - hcount/line counter pair with registered blank flags and line/frame strobes
module scan_counter #(
  parameter int unsigned H_TOTAL      = antic_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL      = antic_timing_pkg::V_TOTAL,
  parameter int unsigned HBLANK_END   = antic_timing_pkg::HBLANK_END,
  parameter int unsigned VBLANK_END   = antic_timing_pkg::VBLANK_END,
  parameter int unsigned VBLANK_START = antic_timing_pkg::VBLANK_START
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] hcount,
  output logic [8:0] line,
  output logic       hblank,
  output logic       vblank,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [7:0] H_LAST   = 8'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [7:0] HB_END   = 8'(HBLANK_END);
  localparam logic [8:0] VB_END   = 9'(VBLANK_END);
  localparam logic [8:0] VB_START = 9'(VBLANK_START);

  logic [7:0] h_next;
  logic [8:0] l_next;

  always_comb begin
    h_next = hcount + 8'd1;
    l_next = line;
    if (hcount == H_LAST) begin
      h_next = 8'd0;
      l_next = (line == V_LAST) ? 9'd0 : line + 9'd1;
    end
  end

  // Flags decode the next counter values so they line up with the counters they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 8'd0;
      line        <= 9'd0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      line        <= l_next;
      hblank      <= (h_next < HB_END);
      vblank      <= (l_next < VB_END) || (l_next >= VB_START);
      line_start  <= (h_next == 8'd0);
      frame_start <= (h_next == 8'd0) && (l_next == 9'd0);
    end
  end

endmodule

// File: rtl/antic_scan_timer.sv
// rtl/antic_scan_timer.sv - scan timing top: counters, WSYNC stall FSM, NMI pulse FSM and NMIST
module antic_scan_timer #(
  parameter int unsigned H_TOTAL       = antic_timing_pkg::H_TOTAL,
  parameter int unsigned HBLANK_END    = antic_timing_pkg::HBLANK_END,
  parameter int unsigned V_TOTAL       = antic_timing_pkg::V_TOTAL,
  parameter int unsigned VBLANK_END    = antic_timing_pkg::VBLANK_END,
  parameter int unsigned VBLANK_START  = antic_timing_pkg::VBLANK_START,
  parameter int unsigned WSYNC_RELEASE = antic_timing_pkg::WSYNC_RELEASE,
  parameter int unsigned NMI_H_POS     = antic_timing_pkg::NMI_H_POS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wsync_wr,
  input  logic       nmires_wr,
  input  logic [7:0] nmien,
  input  logic       dli_req,
  output logic [7:0] hcount,
  output logic [8:0] line,
  output logic [7:0] VCOUNT,
  output logic       hblank,
  output logic       vblank,
  output logic       line_start,
  output logic       frame_start,
  output logic       rdy,
  output logic       nmi_l,
  output logic [7:0] nmist
);

  import antic_timing_pkg::*;

  localparam logic [7:0] WS_POS   = 8'(WSYNC_RELEASE);
  localparam logic [7:0] NMI_POS  = 8'(NMI_H_POS);
  localparam logic [8:0] VBI_LINE = 9'(VBLANK_START);

  scan_counter #(
    .H_TOTAL      (H_TOTAL),
    .V_TOTAL      (V_TOTAL),
    .HBLANK_END   (HBLANK_END),
    .VBLANK_END   (VBLANK_END),
    .VBLANK_START (VBLANK_START)
  ) u_scan_counter (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .line        (line),
    .hblank      (hblank),
    .vblank      (vblank),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  assign VCOUNT = line[8:1];

  logic at_release;
  logic at_nmi;
  assign at_release = (hcount == WS_POS);
  assign at_nmi     = (hcount == NMI_POS);

  wsync_state_t ws_state, ws_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ws_state <= WS_RUN;
    else     ws_state <= ws_next;
  end

  // A write landing on the release position still stalls until the next line's release.
  always_comb begin
    ws_next = ws_state;
    rdy     = 1'b1;
    case (ws_state)
      WS_RUN:  if (wsync_wr) ws_next = WS_WAIT;
      WS_WAIT: begin
        rdy = 1'b0;
        if (at_release) ws_next = WS_RUN;
      end
      default: ws_next = WS_RUN;
    endcase
  end

  logic dli_pend;
  logic dli_fire;
  logic vbi_fire;
  logic dli_st;
  logic vbi_st;

  assign dli_fire = at_nmi && dli_pend && nmien[NMIST_DLI];
  assign vbi_fire = at_nmi && (line == VBI_LINE) && nmien[NMIST_VBI];

  logic unused_nmien;
  assign unused_nmien = ^nmien[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dli_pend <= 1'b0;
    else     dli_pend <= dli_req || (dli_pend && !at_nmi);
  end

  nmi_state_t nmi_state, nmi_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nmi_state <= NMI_IDLE;
    else     nmi_state <= nmi_next;
  end

  always_comb begin
    nmi_next = nmi_state;
    nmi_l    = 1'b1;
    case (nmi_state)
      NMI_IDLE: if (dli_fire || vbi_fire) nmi_next = NMI_P1;
      NMI_P1: begin
        nmi_l    = 1'b0;
        nmi_next = NMI_P2;
      end
      NMI_P2: begin
        nmi_l    = 1'b0;
        nmi_next = NMI_IDLE;
      end
      default: nmi_next = NMI_IDLE;
    endcase
  end

  // Status bits record every firing source, even one whose pulse was swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dli_st <= 1'b0;
      vbi_st <= 1'b0;
    end else begin
      dli_st <= dli_fire || (dli_st && !nmires_wr);
      vbi_st <= vbi_fire || (vbi_st && !nmires_wr);
    end
  end

  assign nmist = {dli_st, vbi_st, 6'b000000};

endmodule

// File: tb/tb_antic_scan_timer.sv
// tb/tb_antic_scan_timer.sv - randomized self-checking bench against an arithmetic timing model
module tb_antic_scan_timer;

  localparam int HT      = 228;
  localparam int VT      = 262;
  localparam int FRAME   = HT * VT;
  localparam int WS_REL  = 220;
  localparam int NMI_POS = 16;
  localparam int VB_ST   = 248;

  logic       clk, rst, wsync_wr, nmires_wr, dli_req;
  logic [7:0] nmien;
  logic [7:0] hcount, VCOUNT, nmist;
  logic [8:0] line;
  logic       hblank, vblank, line_start, frame_start, rdy, nmi_l;

  int checks, passed;
  int k, wr_k, stall_end, pulse_k;
  bit dli_pend_m;
  logic [7:0] nmist_m;

  antic_scan_timer dut (
    .clk(clk), .rst(rst), .wsync_wr(wsync_wr), .nmires_wr(nmires_wr), .nmien(nmien),
    .dli_req(dli_req), .hcount(hcount), .line(line), .VCOUNT(VCOUNT), .hblank(hblank),
    .vblank(vblank), .line_start(line_start), .frame_start(frame_start), .rdy(rdy),
    .nmi_l(nmi_l), .nmist(nmist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_h(); return k % HT; endfunction
  function automatic int cur_l(); return (k / HT) % VT; endfunction
  function automatic logic exp_rdy(); return !(k > wr_k && k <= stall_end); endfunction
  function automatic logic exp_nmi_l(); return !(k >= pulse_k && k <= pulse_k + 1); endfunction

  function automatic logic [35:0] exp_counters();
    int h, l;
    h = cur_h();
    l = cur_l();
    return {8'(h), 9'(l), 8'(l / 2), 1'(h < 68), 1'(l < 8 || l >= VB_ST),
            1'(k > 0 && h == 0), 1'(k > 0 && h == 0 && l == 0), 7'd0};
  endfunction

  task automatic model_reset();
    k = 0; wr_k = -1; stall_end = -1; pulse_k = -10;
    dli_pend_m = 1'b0; nmist_m = 8'h00;
  endtask

  // Advance the model by the inputs present this cycle, then clock the DUT.
  task automatic tick();
    int hc, ln, d;
    logic [7:0] set_bits;
    hc = cur_h(); ln = cur_l(); set_bits = 8'h00;
    if (wsync_wr && exp_rdy()) begin
      d = (WS_REL - hc + HT) % HT;
      if (d == 0) d = HT;
      wr_k = k; stall_end = k + d;
    end
    if (hc == NMI_POS) begin
      if (dli_pend_m && nmien[7]) set_bits[7] = 1'b1;
      if (ln == VB_ST && nmien[6]) set_bits[6] = 1'b1;
      if (set_bits != 8'h00 && exp_nmi_l()) pulse_k = k + 1;
      dli_pend_m = 1'b0;
    end
    if (dli_req) dli_pend_m = 1'b1;
    if (nmires_wr) nmist_m = nmist_m & 8'h3F;
    nmist_m = nmist_m | set_bits;
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic goto_pos(input int ln, input int hc);
    int n;
    n = 0;
    while (!(cur_l() == ln && cur_h() == hc) && n < 70000) begin
      tick();
      n++;
    end
    checks++;
    if (!(cur_l() == ln && cur_h() == hc)) $display("FAIL goto got line %0d h %0d want line %0d h %0d", cur_l(), cur_h(), ln, hc);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; wsync_wr = 1'b0; nmires_wr = 1'b0; dli_req = 1'b0; nmien = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if ({hcount, line, VCOUNT} !== 25'd0) $display("FAIL reset_counters got h %0d line %0d vc %0d want 0", hcount, line, VCOUNT);
    else passed++;
    checks++;
    if ({hblank, vblank, line_start, frame_start} !== 4'b1100) $display("FAIL reset_flags got %b want 1100", {hblank, vblank, line_start, frame_start});
    else passed++;
    checks++;
    if ({rdy, nmi_l, nmist} !== {2'b11, 8'h00}) $display("FAIL reset_cpu got rdy %b nmi_l %b nmist %h want 1 1 00", rdy, nmi_l, nmist);
    else passed++;
    tick();
    checks++;
    if (hcount !== 8'd1) $display("FAIL first_count got %0d want 1", hcount);
    else passed++;
  endtask

  task automatic test_full_frame();
    int fs_count, fs_at, active;
    fs_count = 0; fs_at = -1; active = 0;
    nmien = 8'h00;
    while (k < FRAME) begin
      wsync_wr  = ($urandom_range(0, 399) == 0);
      nmires_wr = ($urandom_range(0, 299) == 0);
      dli_req   = (cur_h() != NMI_POS) && ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({hcount, line, VCOUNT, hblank, vblank, line_start, frame_start, 7'd0} !== exp_counters())
        $display("FAIL frame_counters k %0d got %h want %h", k, {hcount, line, VCOUNT, hblank, vblank, line_start, frame_start, 7'd0}, exp_counters());
      else passed++;
      checks++;
      if (rdy !== exp_rdy()) $display("FAIL frame_rdy k %0d got %b want %b", k, rdy, exp_rdy());
      else passed++;
      checks++;
      if (nmi_l !== 1'b1 || nmist !== 8'h00) $display("FAIL frame_no_nmi k %0d got nmi_l %b nmist %h want 1 00", k, nmi_l, nmist);
      else passed++;
      if (frame_start === 1'b1) begin fs_count++; fs_at = k; end
      if (vblank === 1'b0) active++;
      if (cur_h() == 5 && (cur_l() == 1 || cur_l() == 247)) begin
        checks++;
        if (VCOUNT !== ((cur_l() == 1) ? 8'd0 : 8'd123)) $display("FAIL vcount line %0d got %0d", cur_l(), VCOUNT);
        else passed++;
      end
    end
    wsync_wr = 1'b0; nmires_wr = 1'b0; dli_req = 1'b0;
    checks++;
    if (fs_count != 1 || fs_at != FRAME) $display("FAIL frame_start got count %0d at %0d want 1 at %0d", fs_count, fs_at, FRAME);
    else passed++;
    checks++;
    if (active != 240 * HT) $display("FAIL active_cycles got %0d want %0d", active, 240 * HT);
    else passed++;
    // let any stall from the random writes drain
    repeat (HT + 2) tick();
  endtask

  task automatic test_wsync();
    int n;
    goto_pos(1, 100);
    wsync_wr = 1'b1; tick(); wsync_wr = 1'b0;
    for (int i = 0; i < 121; i++) begin
      checks++;
      if (rdy !== (cur_h() == WS_REL + 1)) $display("FAIL wsync100 h %0d got rdy %b", hcount, rdy);
      else passed++;
      wsync_wr = (cur_h() == 150);
      if (i < 120) tick();
    end
    wsync_wr = 1'b0;
    goto_pos(2, 220);
    wsync_wr = 1'b1; tick(); wsync_wr = 1'b0;
    n = 1;
    while (rdy !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n != 229 || hcount !== 8'd221 || line !== 9'd3) $display("FAIL wsync220 got %0d clocks line %0d h %0d want 229 3 221", n, line, hcount);
    else passed++;
  endtask

  task automatic test_dli_vbi();
    nmien = 8'hC0;
    goto_pos(247, 50);
    dli_req = 1'b1; tick(); dli_req = 1'b0;
    goto_pos(248, 16);
    checks++;
    if (nmi_l !== 1'b1 || nmist !== 8'h00) $display("FAIL nmi_before got %b %h want 1 00", nmi_l, nmist);
    else passed++;
    for (int i = 17; i <= 19; i++) begin
      tick();
      checks++;
      if (nmi_l !== (i == 19) || nmist !== 8'hC0 || nmi_l !== exp_nmi_l())
        $display("FAIL nmi_pulse h %0d got nmi_l %b nmist %h want %b C0", hcount, nmi_l, nmist, (i == 19));
      else passed++;
    end
    goto_pos(248, 30);
    nmires_wr = 1'b1; tick(); nmires_wr = 1'b0;
    checks++;
    if (nmist !== 8'h00 || nmist_m !== 8'h00) $display("FAIL nmires got %h want 00", nmist);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    nmien = 8'h80;
    goto_pos(248, 60);
    dli_req = 1'b1; tick(); dli_req = 1'b0;
    goto_pos(249, 5);
    wsync_wr = 1'b1; tick(); wsync_wr = 1'b0;
    goto_pos(249, 18);
    checks++;
    if (rdy !== 1'b0 || nmi_l !== 1'b0 || nmist !== 8'h80) $display("FAIL pre_reset got rdy %b nmi_l %b nmist %h want 0 0 80", rdy, nmi_l, nmist);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1 || nmi_l !== 1'b1 || hcount !== 8'd0 || line !== 9'd0 || nmist !== 8'h00)
      $display("FAIL async_reset got rdy %b nmi_l %b h %0d line %0d nmist %h", rdy, nmi_l, hcount, line, nmist);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (hcount !== 8'd0) $display("FAIL reset_hold got %0d want 0", hcount);
    else passed++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random_resume();
    logic [7:0] modes [4];
    modes[0] = 8'h00; modes[1] = 8'h40; modes[2] = 8'h80; modes[3] = 8'hC0;
    nmien = modes[$urandom_range(2, 3)];
    for (int i = 0; i < 3 * HT; i++) begin
      wsync_wr  = ($urandom_range(0, 59) == 0);
      nmires_wr = ($urandom_range(0, 79) == 0);
      dli_req   = (cur_h() != NMI_POS) && ($urandom_range(0, 99) == 0);
      if (i == HT) nmien = modes[$urandom_range(0, 3)];
      tick();
      checks++;
      if (hcount !== 8'(cur_h()) || rdy !== exp_rdy() || nmi_l !== exp_nmi_l() || nmist !== nmist_m)
        $display("FAIL resume k %0d got h %0d rdy %b nmi_l %b nmist %h want %0d %b %b %h",
                 k, hcount, rdy, nmi_l, nmist, cur_h(), exp_rdy(), exp_nmi_l(), nmist_m);
      else passed++;
    end
    wsync_wr = 1'b0; nmires_wr = 1'b0; dli_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    model_reset();
    test_reset();
    test_full_frame();
    test_wsync();
    test_dli_vbi();
    test_reset_midrun();
    test_random_resume();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
